// File: rtl/bus_arbiter.sv
// Purpose: shares the memory bus between the processor and a second master (D), freezing the processor while D owns it.
// Latency: D is granted one cycle after d_req is seen with cool-down expired; d_rvalid follows a D read by one cycle.
// Backpressure: D holds d_req to wait for a grant; the processor is stalled via proc_run. ARB_STATS_EN adds a grant counter.
module bus_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int MAX_BURST = 4
) (
  input  logic          Clock,
  input  logic          Resetn,
  input  logic          run_in,
  output logic          proc_run,
  input  logic [AW-1:0] p_addr,
  input  logic [DW-1:0] p_dout,
  input  logic          p_w,
  input  logic          d_req,
  input  logic [AW-1:0] d_addr,
  input  logic [DW-1:0] d_dout,
  input  logic          d_w,
  output logic          d_gnt,
  output logic          d_rvalid,
  output logic [AW-1:0] bus_addr,
  output logic [DW-1:0] bus_dout,
  output logic          bus_w,
  output logic [15:0]   stat_cnt
);

  typedef enum logic [1:0] {P_OWN, D_OWN, D_TAIL} state_t;

  // The burst limit doubles as the processor's guaranteed run window after each tail.
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
  localparam logic [7:0] COOL_LOAD  = 8'(MAX_BURST);

  state_t     state_q, state_d;
  logic [7:0] burst_q, burst_d;
  logic [7:0] cool_q, cool_d;
  logic       rvalid_q, rvalid_d;

  // Next-state: grant after cool-down, cap bursts, one tail cycle to refetch the processor's address.
  always_comb begin
    state_d  = state_q;
    burst_d  = burst_q;
    cool_d   = cool_q;
    rvalid_d = 1'b0;
    case (state_q)
      P_OWN: begin
        burst_d = 8'd0;
        cool_d  = (cool_q != 8'd0) ? cool_q - 8'd1 : 8'd0;
        if (d_req && (cool_q == 8'd0)) begin
          state_d = D_OWN;
        end
      end
      D_OWN: begin
        rvalid_d = ~d_w;
        if (!d_req || (burst_q == BURST_LAST)) begin
          state_d = D_TAIL;
          burst_d = 8'd0;
        end else begin
          burst_d = burst_q + 8'd1;
        end
      end
      D_TAIL: begin
        state_d = P_OWN;
        cool_d  = COOL_LOAD;
      end
      default: begin
        state_d = P_OWN;
        burst_d = 8'd0;
        cool_d  = 8'd0;
      end
    endcase
  end

  // State and counter registers.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q  <= P_OWN;
      burst_q  <= 8'd0;
      cool_q   <= 8'd0;
      rvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      burst_q  <= burst_d;
      cool_q   <= cool_d;
      rvalid_q <= rvalid_d;
    end
  end

  // Bus mux and processor gating, purely from state; the tail re-presents p_addr with writes suppressed.
  always_comb begin
    bus_addr = p_addr;
    bus_dout = p_dout;
    bus_w    = 1'b0;
    proc_run = 1'b0;
    d_gnt    = 1'b0;
    case (state_q)
      P_OWN: begin
        bus_w    = p_w;
        proc_run = run_in;
      end
      D_OWN: begin
        bus_addr = d_addr;
        bus_dout = d_dout;
        bus_w    = d_w;
        d_gnt    = 1'b1;
      end
      default: begin
        bus_w = 1'b0;
      end
    endcase
  end

  assign d_rvalid = rvalid_q;

`ifdef ARB_STATS_EN
  logic [15:0] stat_q, stat_d;

  // Count D-owned cycles, saturating rather than wrapping.
  always_comb begin
    stat_d = stat_q;
    if ((state_q == D_OWN) && (stat_q != 16'hFFFF)) begin
      stat_d = stat_q + 16'd1;
    end
  end

  // Statistics register, cleared only by reset.
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      stat_q <= 16'd0;
    end else begin
      stat_q <= stat_d;
    end
  end

  assign stat_cnt = stat_q;
`else
  assign stat_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Purpose: self-checking bench for bus_arbiter (vector table through a scoreboard queue, plus reset and burst sequences).
// Latency: each vector is driven just after a rising edge and compared on the following falling edge.
// Backpressure: not applicable; every wait is bounded by a cycle budget or a global watchdog.
module tb_bus_arbiter;

  localparam logic        T  = 1'b1;
  localparam logic        F  = 1'b0;
  localparam logic [15:0] PA = 16'h0042;
  localparam logic [15:0] PD = 16'h7777;
  localparam logic [15:0] DA = 16'h2000;
  localparam logic [15:0] DD = 16'h00D0;
  localparam logic [15:0] WA = 16'h1000;
  localparam logic [15:0] WD = 16'h01A5;
  localparam logic [15:0] RA = 16'h0005;

`ifdef ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        Clock, Resetn, run_in, proc_run;
  logic [15:0] p_addr, p_dout, d_addr, d_dout, bus_addr, bus_dout, stat_cnt;
  logic        p_w, d_req, d_w, d_gnt, d_rvalid, bus_w;

  bus_arbiter #(.AW(16), .DW(16), .MAX_BURST(4)) dut (
    .Clock(Clock), .Resetn(Resetn), .run_in(run_in), .proc_run(proc_run),
    .p_addr(p_addr), .p_dout(p_dout), .p_w(p_w),
    .d_req(d_req), .d_addr(d_addr), .d_dout(d_dout), .d_w(d_w),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid),
    .bus_addr(bus_addr), .bus_dout(bus_dout), .bus_w(bus_w), .stat_cnt(stat_cnt)
  );

  typedef struct {
    logic        run, req, dw, pw;
    logic [15:0] da, dd;
    logic        pr, g, rv;
    logic [15:0] ba, bd;
    logic        bw;
    logic [15:0] st;
  } vec_t;

  localparam int NV = 24;
  vec_t vecs[NV];
  vec_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  initial begin
    int bursts, run_len, gap;
    logic prev_g;
    vec_t e;

    // Columns: run req dw pw d_addr d_dout | proc_run d_gnt d_rvalid bus_addr bus_dout bus_w stat
    vecs[0]  = '{T, T, F, F, DA, DD, T, F, F, PA, PD, F, 16'd0};  // arbitration cycle, still the processor's
    vecs[1]  = '{T, T, F, F, DA, DD, F, T, F, DA, DD, F, 16'd0};
    vecs[2]  = '{T, T, F, F, DA, DD, F, T, T, DA, DD, F, 16'd1};
    vecs[3]  = '{T, T, F, F, DA, DD, F, T, T, DA, DD, F, 16'd2};
    vecs[4]  = '{T, T, F, F, DA, DD, F, T, T, DA, DD, F, 16'd3};  // 4th granted cycle
    vecs[5]  = '{T, T, T, T, DA, DD, F, F, T, PA, PD, F, 16'd4};  // tail: strobes ignored
    vecs[6]  = '{T, T, F, T, DA, DD, T, F, F, PA, PD, T, 16'd4};  // cool-down 4
    vecs[7]  = '{T, T, F, F, DA, DD, T, F, F, PA, PD, F, 16'd4};
    vecs[8]  = '{T, T, F, F, DA, DD, T, F, F, PA, PD, F, 16'd4};
    vecs[9]  = '{T, T, F, F, DA, DD, T, F, F, PA, PD, F, 16'd4};
    vecs[10] = '{T, T, F, F, DA, DD, T, F, F, PA, PD, F, 16'd4};  // cool-down expired, arbitration
    vecs[11] = '{T, T, T, T, WA, WD, F, T, F, WA, WD, T, 16'd4};  // D write
    vecs[12] = '{T, T, F, F, RA, DD, F, T, F, RA, DD, F, 16'd5};  // no rvalid after a write
    vecs[13] = '{T, T, F, F, RA, DD, F, T, T, RA, DD, F, 16'd6};
    vecs[14] = '{T, T, F, F, RA, DD, F, T, T, RA, DD, F, 16'd7};
    vecs[15] = '{T, F, F, F, RA, DD, F, F, T, PA, PD, F, 16'd8};  // tail
    vecs[16] = '{T, F, F, F, RA, DD, T, F, F, PA, PD, F, 16'd8};
    vecs[17] = '{F, F, F, F, RA, DD, F, F, F, PA, PD, F, 16'd8};  // run_in low freezes processor
    vecs[18] = '{T, F, F, F, RA, DD, T, F, F, PA, PD, F, 16'd8};
    vecs[19] = '{T, F, F, F, RA, DD, T, F, F, PA, PD, F, 16'd8};
    vecs[20] = '{F, T, F, F, RA, DD, F, F, F, PA, PD, F, 16'd8};  // grant while run_in low
    vecs[21] = '{T, F, F, F, RA, DD, F, T, F, RA, DD, F, 16'd8};  // single-cycle read, d_req dropped
    vecs[22] = '{T, F, F, F, RA, DD, F, F, T, PA, PD, F, 16'd9};  // tail carries rvalid
    vecs[23] = '{T, F, F, F, RA, DD, T, F, F, PA, PD, F, 16'd9};

    Resetn = 1'b0; run_in = 1'b1; d_req = 1'b1; d_w = 1'b0; p_w = 1'b0;
    p_addr = PA; p_dout = PD; d_addr = DA; d_dout = DD;
    @(negedge Clock);
    @(negedge Clock);
    check("reset_proc_run", 32'(proc_run), 32'(1));
    check("reset_d_gnt", 32'(d_gnt), 32'(0));
    check("reset_d_rvalid", 32'(d_rvalid), 32'(0));
    check("reset_stat", 32'(stat_cnt), 32'(0));

    for (int i = 0; i < NV; i++) begin
      @(posedge Clock);
      #1;
      if (i == 0) Resetn = 1'b1;
      run_in = vecs[i].run; d_req = vecs[i].req; d_w = vecs[i].dw; p_w = vecs[i].pw;
      d_addr = vecs[i].da; d_dout = vecs[i].dd; p_addr = PA; p_dout = PD;
      exp_q.push_back(vecs[i]);
      @(negedge Clock);
      e = exp_q.pop_front();
      check($sformatf("v%0d_proc_run", i), 32'(proc_run), 32'(e.pr));
      check($sformatf("v%0d_d_gnt", i), 32'(d_gnt), 32'(e.g));
      check($sformatf("v%0d_d_rvalid", i), 32'(d_rvalid), 32'(e.rv));
      check($sformatf("v%0d_bus_addr", i), 32'(bus_addr), 32'(e.ba));
      check($sformatf("v%0d_bus_dout", i), 32'(bus_dout), 32'(e.bd));
      check($sformatf("v%0d_bus_w", i), 32'(bus_w), 32'(e.bw));
      check($sformatf("v%0d_stat", i), 32'(stat_cnt), STATS ? 32'(e.st) : 32'(0));
    end

    // Reset asserted during the second granted cycle.
    @(posedge Clock);
    #1;
    Resetn = 1'b0; d_req = 1'b1; run_in = 1'b1; d_w = 1'b0; p_w = 1'b0;
    @(posedge Clock);
    #1;
    Resetn = 1'b1;
    @(posedge Clock);
    #1;
    @(posedge Clock);
    #1;
    check("mid_d_gnt", 32'(d_gnt), 32'(1));
    check("mid_d_rvalid", 32'(d_rvalid), 32'(1));
    check("mid_stat", 32'(stat_cnt), STATS ? 32'(1) : 32'(0));
    #2;
    Resetn = 1'b0;
    #1;
    check("arst_d_gnt", 32'(d_gnt), 32'(0));
    check("arst_d_rvalid", 32'(d_rvalid), 32'(0));
    check("arst_stat", 32'(stat_cnt), 32'(0));
    check("arst_proc_run", 32'(proc_run), 32'(1));
    check("arst_bus_addr", 32'(bus_addr), 32'(PA));
    d_req = 1'b0;
    @(posedge Clock);
    #1;
    Resetn = 1'b1;
    @(negedge Clock);
    check("post_proc_run", 32'(proc_run), 32'(1));
    check("post_d_gnt", 32'(d_gnt), 32'(0));

    // Three full bursts with d_req held: length 4 each, processor gets at least 4 cycles between.
    @(posedge Clock);
    #1;
    d_req = 1'b1;
    bursts = 0; run_len = 0; gap = 0; prev_g = 1'b0;
    for (int cyc = 0; cyc < 80 && bursts < 3; cyc++) begin
      @(negedge Clock);
      if (d_gnt) begin
        if (!prev_g && bursts > 0) check("gap_ge4", 32'(gap >= 4), 32'(1));
        run_len++;
        gap = 0;
      end else begin
        if (prev_g) begin
          check("burst_len", 32'(run_len), 32'(4));
          check("tail_bus_w", 32'(bus_w), 32'(0));
          check("tail_bus_addr", 32'(bus_addr), 32'(PA));
          bursts++;
          run_len = 0;
        end
        if (proc_run) gap++;
      end
      prev_g = d_gnt;
    end
    check("bursts_seen", 32'(bursts), 32'(3));
    d_req = 1'b0;
    @(negedge Clock);
    check("stat_after_3", 32'(stat_cnt), STATS ? 32'(12) : 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
